// File: rtl/irda_pkg.sv
// Shared types and framing constants for the IrDA SIR transmit path.
package irda_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam int   FRAME_BITS = 10;
   localparam int   OVS        = 16;
   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;

   // Build the on-air frame: stop bit at the MSB, start bit at the LSB so
   // that shifting right emits start, data LSB first, then stop.
   function automatic logic [FRAME_BITS-1:0] frame_byte(input logic [7:0] data);
      return {STOP_BIT, data, START_BIT};
   endfunction

endpackage : irda_pkg

// File: rtl/irda_tx_baud.sv
// Sub-bit timing for the transmitter: divides clk down to 1/16-bit sub-ticks
// and counts sub-ticks within a bit period.
module irda_tx_baud
   import irda_pkg::*;
#(
   parameter int OVS_DIV = 27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic       clear,
   output logic       tick,
   output logic [3:0] sub_cnt,
   output logic       bit_end
);

   localparam int DIV_W = $clog2(OVS_DIV);

   logic [DIV_W-1:0] div_cnt;

   // A tick only counts while running; clear holds both counters at zero so a
   // new frame always starts at the beginning of a bit period.
   assign tick    = ena && !clear && (div_cnt == DIV_W'(OVS_DIV - 1));
   assign bit_end = tick && (sub_cnt == 4'(OVS - 1));

   // Divider and sub-tick counter; both freeze while ena is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         sub_cnt <= 4'd0;
      end else if (clear) begin
         div_cnt <= '0;
         sub_cnt <= 4'd0;
      end else if (tick) begin
         div_cnt <= '0;
         sub_cnt <= sub_cnt + 4'd1;
      end else if (ena) begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule : irda_tx_baud

// File: rtl/irda_transmitter.sv
// IrDA SIR transmitter: accepts a byte over valid/ready, frames it as
// start + 8 data (LSB first) + stop, and sends each 0 bit as a short pulse.
module irda_transmitter
   import irda_pkg::*;
#(
   parameter int OVS_DIV = 27,
   parameter int PULSE_W = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       txir,
   output logic       done
);

   state_t                  state;
   state_t                  state_next;
   logic [FRAME_BITS-1:0]   shreg;
   logic [3:0]              bit_cnt;
   logic [3:0]              sub_cnt;
   logic                    tick;
   logic                    bit_end;
   logic                    accept;
   logic                    last_bit;

   assign tx_ready = (state == IDLE);
   assign busy     = (state == SEND);
   assign accept   = tx_valid && tx_ready && ena;
   assign last_bit = (bit_cnt == 4'(FRAME_BITS - 1));

   irda_tx_baud #(
      .OVS_DIV (OVS_DIV)
   ) u_baud (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .clear   (tx_ready),
      .tick    (tick),
      .sub_cnt (sub_cnt),
      .bit_end (bit_end)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: leave IDLE on acceptance, return after the stop bit period.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = SEND;
         SEND: if (bit_end && last_bit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Shift register, bit counter, done pulse and registered pulse output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg   <= {FRAME_BITS{1'b1}};
         bit_cnt <= 4'd0;
         done    <= 1'b0;
         txir    <= 1'b0;
      end else begin
         done <= 1'b0;
         txir <= (state == SEND) && ena && (shreg[0] == START_BIT)
                 && (sub_cnt < 4'(PULSE_W));
         if (accept) begin
            shreg   <= frame_byte(tx_data);
            bit_cnt <= 4'd0;
         end else if ((state == SEND) && tick) begin
            if (bit_end) begin
               if (last_bit) begin
                  done <= 1'b1;
               end else begin
                  shreg   <= {STOP_BIT, shreg[FRAME_BITS-1:1]};
                  bit_cnt <= bit_cnt + 4'd1;
               end
            end
         end
      end
   end

endmodule : irda_transmitter
